// File: rtl/auth_cmd_tx.sv
// Host-side command transmitter for the Auth_blk link.
// Queues go/stop commands and sends each as one UART 8N1 frame on TX.
module auth_cmd_tx #(
    parameter int       BAUD_DIV   = 2604,
    parameter int       FIFO_DEPTH = 4,
    parameter bit [7:0] GO_BYTE    = 8'h67,
    parameter bit [7:0] STOP_BYTE  = 8'h73
) (
    input  logic clk,
    input  logic rst,
    input  logic send_go,
    input  logic send_stop,
    output logic TX,
    output logic busy,
    output logic full,
    output logic tx_done,
    output logic ovfl
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_baud;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    logic                  r_tx;
    logic                  r_done;
    logic                  r_ovfl;
    logic [FIFO_DEPTH-1:0] r_mem;
    logic [AW-1:0]         r_wr;
    logic [AW-1:0]         r_rd;
    logic [AW:0]           r_count;

    logic       w_req;
    logic       w_last;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic [7:0] w_byte;

    assign w_req   = send_go | send_stop;
    assign w_last  = (r_baud == CW'(BAUD_DIV - 1));
    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    // Pops happen only where a new frame is loaded.
    assign w_pop   = !w_empty &&
                     ((r_state == IDLE) || (r_state == STOP && w_last));
    assign w_push  = w_req && (!w_full || w_pop);
    assign w_drop  = w_req && w_full && !w_pop;
    assign w_byte  = r_mem[r_rd] ? STOP_BYTE : GO_BYTE;

    assign TX      = r_tx;
    assign busy    = (r_state != IDLE) || !w_empty;
    assign full    = w_full;
    assign tx_done = r_done;
    assign ovfl    = r_ovfl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_ovfl  <= 1'b0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            r_ovfl <= w_drop;

            if (w_push) begin
                r_mem[r_wr] <= send_stop;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - (AW+1)'(1);

            unique case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_byte;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_last) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                DATA: begin
                    if (w_last) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                STOP: begin
                    // Registered pulse lands on the stop bit's final cycle.
                    r_done <= (r_baud == CW'(BAUD_DIV - 2));
                    if (w_last) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_byte;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_auth_cmd_tx.sv
// Directed bench for auth_cmd_tx with a small baud divisor.
// A TX monitor decodes frames and logs tx_done/ovfl cycles.
module tb_auth_cmd_tx;

    localparam int B = 16;

    logic clk = 1'b0;
    logic rst;
    logic send_go;
    logic send_stop;
    logic TX;
    logic busy;
    logic full;
    logic tx_done;
    logic ovfl;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int         falls[$];
    logic [7:0] bytes[$];
    int         dones[$];
    int         n_ovfl;

    logic       mon_act = 1'b0;
    int         mon_cnt;
    logic [7:0] mon_byte;

    auth_cmd_tx #(.BAUD_DIV(B), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .send_go  (send_go),
        .send_stop(send_stop),
        .TX       (TX),
        .busy     (busy),
        .full     (full),
        .tx_done  (tx_done),
        .ovfl     (ovfl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_done) dones.push_back(cyc);
        if (ovfl) n_ovfl++;
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (TX == 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                falls.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == B/2) check("start_bit", 32'(TX), 0);
            for (int k = 1; k <= 8; k++)
                if (mon_cnt == k*B + B/2) mon_byte[k-1] = TX;
            if (mon_cnt == 9*B + B/2) begin
                check("stop_bit", 32'(TX), 1);
                bytes.push_back(mon_byte);
            end
            if (mon_cnt == 10*B - 1) mon_act = 1'b0;
        end
    end

    task automatic clear_log();
        falls.delete();
        bytes.delete();
        dones.delete();
        n_ovfl = 0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while ((busy || mon_act) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < limit), 1);
    endtask

    // Drive a one-cycle request; returns the sampling edge number.
    task automatic pulse(input logic g, input logic s, output int k);
        @(negedge clk);
        send_go   = g;
        send_stop = s;
        k         = cyc + 1;
        @(negedge clk);
        send_go   = 1'b0;
        send_stop = 1'b0;
    endtask

    int k0;
    int k1;

    initial begin
        rst = 1'b1;
        send_go = 1'b0;
        send_stop = 1'b0;
        n_ovfl = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx", 32'(TX), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_full", 32'(full), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_ovfl", 32'(ovfl), 0);

        // Single go frame
        clear_log();
        pulse(1'b1, 1'b0, k0);
        check("go_busy", 32'(busy), 1);
        wait_idle("go_idle", 20*B);
        check("go_nfr", 32'(bytes.size()), 1);
        if (bytes.size() > 0) check("go_byte", 32'(bytes[0]), 32'h67);
        if (falls.size() > 0) check("go_fall", 32'(falls[0]), 32'(k0 + 1));
        check("go_ndone", 32'(dones.size()), 1);
        if (dones.size() > 0 && falls.size() > 0)
            check("go_done_t", 32'(dones[0]), 32'(falls[0] + 10*B - 1));

        // go then stop 5 cycles later: back-to-back frames
        clear_log();
        pulse(1'b1, 1'b0, k0);
        repeat (3) @(negedge clk);
        pulse(1'b0, 1'b1, k1);
        wait_idle("b2b_idle", 40*B);
        check("b2b_nfr", 32'(bytes.size()), 2);
        if (bytes.size() == 2) begin
            check("b2b_byte0", 32'(bytes[0]), 32'h67);
            check("b2b_byte1", 32'(bytes[1]), 32'h73);
        end
        if (falls.size() == 2)
            check("b2b_gap", 32'(falls[1] - falls[0]), 32'(10*B));
        check("b2b_ndone", 32'(dones.size()), 2);
        check("b2b_busy", 32'(busy), 0);

        // Simultaneous go and stop: stop wins
        clear_log();
        pulse(1'b1, 1'b1, k0);
        wait_idle("both_idle", 20*B);
        check("both_nfr", 32'(bytes.size()), 1);
        if (bytes.size() > 0) check("both_byte", 32'(bytes[0]), 32'h73);
        check("both_ovfl", 32'(n_ovfl), 0);

        // Six consecutive go requests: fifth fills, sixth drops
        clear_log();
        @(negedge clk);
        send_go = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 4) check("six_full4", 32'(full), 0);
            if (i == 5) check("six_full5", 32'(full), 1);
            if (i == 6) begin
                send_go = 1'b0;
                check("six_ovfl", 32'(ovfl), 1);
            end
        end
        wait_idle("six_idle", 60*B);
        check("six_nfr", 32'(bytes.size()), 5);
        foreach (bytes[i]) check("six_byte", 32'(bytes[i]), 32'h67);
        check("six_novfl", 32'(n_ovfl), 1);
        check("six_ndone", 32'(dones.size()), 5);

        // Reset in the middle of data bit 3
        clear_log();
        pulse(1'b1, 1'b0, k0);
        k1 = 0;
        while (falls.size() == 0 && k1 < 10) begin
            @(negedge clk);
            k1++;
        end
        check("rstm_fall", 32'(falls.size()), 1);
        if (falls.size() > 0)
            while (cyc < falls[0] + 4*B + B/2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstm_tx", 32'(TX), 1);
        check("rstm_busy", 32'(busy), 0);
        repeat (12*B) @(negedge clk);
        check("rstm_nfr", 32'(bytes.size()), 0);
        check("rstm_ndone", 32'(dones.size()), 0);
        check("rstm_falls", 32'(falls.size()), 1);

        // Request on the pop edge while full
        clear_log();
        @(negedge clk);
        send_go = 1'b1;
        repeat (5) @(negedge clk);
        send_go = 1'b0;
        check("pop_full", 32'(full), 1);
        if (falls.size() > 0) begin
            while (cyc < falls[0] + 10*B - 1) @(negedge clk);
            send_stop = 1'b1;
            @(negedge clk);
            send_stop = 1'b0;
            check("pop_full_kept", 32'(full), 1);
            check("pop_no_ovfl", 32'(ovfl), 0);
        end
        wait_idle("pop_idle", 80*B);
        check("pop_nfr", 32'(bytes.size()), 6);
        if (bytes.size() == 6) check("pop_last", 32'(bytes[5]), 32'h73);
        check("pop_novfl", 32'(n_ovfl), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
